// File: rtl/half_adder.sv
// half_adder: registered array of WIDTH independent 1-bit half adders with valid flag and saturating carry counter
// Ports: clk, rst (sync active-high); a, b (WIDTH operands); in_valid qualifies a/b;
//        h (per-lane carry), l (per-lane sum), out_valid, carry_any (OR of h), carry_count (saturating)
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] l,
  output logic             out_valid,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
);
  logic [WIDTH-1:0] h_q, h_d, l_q, l_d;
  logic             v_q, any_q, any_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    h_d   = in_valid ? a & b : h_q;
    l_d   = in_valid ? a ^ b : l_q;
    any_d = in_valid ? |(a & b) : any_q;
    cnt_d = (in_valid && |(a & b) && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      l_q   <= '0;
      any_q <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      h_q   <= h_d;
      l_q   <= l_d;
      any_q <= any_d;
      v_q   <= in_valid;
      cnt_q <= cnt_d;
    end
  end
  assign h           = h_q;
  assign l           = l_q;
  assign carry_any   = any_q;
  assign out_valid   = v_q;
  assign carry_count = cnt_q;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench for a 1-lane/2-bit-counter and a 4-lane/16-bit-counter half_adder
module tb_half_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       a2 = 1'b0, b2 = 1'b0, v2 = 1'b0;
  logic       h2, l2, ov2, any2;
  logic [1:0] cnt2;
  logic [3:0] a4 = '0, b4 = '0;
  logic       v4 = 1'b0;
  logic [3:0] h4, l4;
  logic       ov4, any4;
  logic [15:0] cnt4;
  half_adder #(.WIDTH(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(v2),
    .h(h2), .l(l2), .out_valid(ov2), .carry_any(any2), .carry_count(cnt2)
  );
  half_adder #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .h(h4), .l(l4), .out_valid(ov4), .carry_any(any4), .carry_count(cnt4)
  );
  typedef struct packed {logic [3:0] h; logic [3:0] l;} res_t;
  res_t q2[$], q4[$];
  logic [3:0] eh2 = '0, el2 = '0, eh4 = '0, el4 = '0;
  int cnt2_m = 0, cnt4_m = 0;
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op2(input logic a, input logic b, input logic v);
    res_t r;
    @(negedge clk);
    a2 = a; b2 = b; v2 = v; v4 = 1'b0;
    if (v) q2.push_back({3'b0, a & b, 3'b0, a ^ b});
    @(posedge clk);
    #1;
    if (v && (a & b) && cnt2_m < 3) cnt2_m++;
    chk("ov2", ov2, v);
    if (ov2) begin
      if (q2.size() == 0) chk("q2_underflow", 1, 0);
      else begin
        r = q2.pop_front();
        eh2 = r.h; el2 = r.l;
      end
    end
    chk("h2", h2, eh2);
    chk("l2", l2, el2);
    chk("any2", any2, |eh2);
    chk("cnt2", cnt2, cnt2_m);
  endtask
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic v);
    res_t r;
    @(negedge clk);
    a4 = a; b4 = b; v4 = v; v2 = 1'b0;
    if (v) q4.push_back({a & b, a ^ b});
    @(posedge clk);
    #1;
    if (v && |(a & b) && cnt4_m < 65535) cnt4_m++;
    chk("ov4", ov4, v);
    if (ov4) begin
      if (q4.size() == 0) chk("q4_underflow", 1, 0);
      else begin
        r = q4.pop_front();
        eh4 = r.h; el4 = r.l;
      end
    end
    chk("h4", h4, eh4);
    chk("l4", l4, el4);
    chk("any4", any4, |eh4);
    chk("cnt4", cnt4, cnt4_m);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    a2 = 1'b1; b2 = 1'b1; v2 = 1'b1;
    a4 = '1; b4 = '1; v4 = 1'b1;
    @(posedge clk);
    #1;
    q2.delete(); q4.delete();
    eh2 = '0; el2 = '0; eh4 = '0; el4 = '0;
    cnt2_m = 0; cnt4_m = 0;
    chk("rst_h2", h2, 0);
    chk("rst_l2", l2, 0);
    chk("rst_ov2", ov2, 0);
    chk("rst_any2", any2, 0);
    chk("rst_cnt2", cnt2, 0);
    chk("rst_h4", h4, 0);
    chk("rst_l4", l4, 0);
    chk("rst_ov4", ov4, 0);
    chk("rst_any4", any4, 0);
    chk("rst_cnt4", cnt4, 0);
    @(negedge clk);
    rst = 1'b0; v2 = 1'b0; v4 = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    rst_pulse();
    op2(1'b0, 1'b0, 1'b1);
    op2(1'b0, 1'b1, 1'b1);
    op2(1'b1, 1'b0, 1'b1);
    op2(1'b1, 1'b1, 1'b1);
    op2(1'b0, 1'b0, 1'b1);
    chk("tt_cnt_end", cnt2, 1);
    op2(1'b1, 1'b1, 1'b1);
    rst_pulse();
    op2(1'b1, 1'b1, 1'b1);
    op2(1'b0, 1'b0, 1'b0);
    op2(1'b0, 1'b0, 1'b0);
    chk("hold_h", h2, 1);
    chk("hold_cnt", cnt2, 1);
    op4(4'b1100, 4'b1010, 1'b1);
    chk("ml_h", h4, 4'b1000);
    op4(4'b0101, 4'b1010, 1'b1);
    chk("ml_l", l4, 4'b1111);
    chk("ml_cnt", cnt4, 1);
    for (int i = 0; i < 8; i++) op4(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b1);
    op4(4'b0000, 4'b0000, 1'b0);
    chk("stream_drained", q4.size(), 0);
    rst_pulse();
    for (int i = 0; i < 5; i++) op2(1'b1, 1'b1, 1'b1);
    chk("sat_cnt", cnt2, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered array of WIDTH independent 1-bit half adders; lane i computes carry (high bit) and sum (low bit) of a[i]+b[i].
- Arithmetic leaf used by adder trees and counters; outputs are registered with a valid flag for clean pipeline insertion.
- Includes a saturating counter of valid transactions that produced at least one carry, for debug and statistics.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 16, width of carry_count statistics counter (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies a/b this cycle.
- h  output  WIDTH  per-lane carry (high bit), a[i] AND b[i]; registered.
- l  output  WIDTH  per-lane sum (low bit), a[i] XOR b[i]; registered.
- out_valid  output  1  h/l/carry_any hold a fresh result this cycle.
- carry_any  output  1  OR of all lanes of h for the current registered result.
- carry_count  output  CNT_W  number of accepted transactions with carry_any=1; saturating.

Behaviour:
- Reset (rst=1 at rising clk edge):
  - h, l, carry_any, out_valid and carry_count are set to 0.
  - Any in-flight result is discarded.
  - rst has priority over in_valid in the same cycle.
- Lane function, per lane, independent and no inter-lane carry:
  - h[i] = a[i] & b[i].
  - l[i] = a[i] ^ b[i].
  - {h[i], l[i]} equals the 2-bit sum a[i]+b[i].
- Latency: exactly 1 clock. Inputs sampled at edge N with in_valid=1 appear on h/l/carry_any at edge N (visible in cycle N+1), with out_valid=1 for that one cycle.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - h, l and carry_any hold their previous values; no update.
  - a and b are don't-care.
- Back-to-back: in_valid=1 on consecutive cycles yields one result per cycle, in order, no bubbles.
- No backpressure: there is no ready signal and the block always accepts.
- carry_any is registered together with h, so it stays consistent with h at all times.
- carry_count:
  - Increments by 1 at an edge where in_valid=1 and (a & b) != 0; changes in the same cycle out_valid rises.
  - Saturates at 2^CNT_W-1 and holds there.
  - Cleared only by rst.
- X/undefined inputs when in_valid=0 must not propagate to outputs or the counter.
- Purely synchronous; no combinational path from inputs to outputs.

Test Plan:
- Truth table, WIDTH=1, one op every 10 ns after reset: (a,b)=(0,0)->h=0,l=0; (0,1)->h=0,l=1; (1,0)->h=0,l=1; (1,1)->h=1,l=0; (0,0)->h=0,l=0. Each result appears 1 cycle after the input with out_valid=1; carry_count ends at 1.
- Reset: drive ops, then rst=1 for 1 cycle with in_valid=1, a=b=1 -> next cycle h=0, l=0, carry_any=0, out_valid=0, carry_count=0.
- Hold: a=1, b=1, in_valid=1 for one cycle, then in_valid=0 with a=0, b=0 -> h=1, l=0 held, out_valid=0 after the first result cycle, carry_count stays 1.
- Multi-lane, WIDTH=4: a=4'b1100, b=4'b1010 -> h=4'b1000, l=4'b0110, carry_any=1; then a=4'b0101, b=4'b1010 -> h=0, l=4'b1111, carry_any=0; carry_count=1.
- Streaming: 8 back-to-back random vectors -> 8 consecutive out_valid pulses; each h/l matches a&b and a^b of its input in order.
- Saturation, CNT_W=2: 5 ops with a=b=1 -> carry_count sequence 1, 2, 3, 3, 3.
